// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: sequential advance,
// branch/jump redirects, stalls with one buffered redirect, and flushes.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_INC       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ce,
  output logic                  pend_valid,
  output logic                  pc_misaligned
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pend_tgt, tgt_nxt, pc_nxt;
  logic                    pend_nxt;

  // State, pc, pending redirect and ROM enable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      ce         <= 1'b0;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ce         <= (state_nxt == RUN);
      pend_valid <= pend_nxt;
      pend_tgt   <= tgt_nxt;
    end
  end

  // Next-state / next-pc selection; control inputs only matter in RUN.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_valid;
    tgt_nxt   = pend_tgt;
    case (state)
      IDLE: begin
        // First fetch is the reset vector itself, so pc is not advanced.
        state_nxt = RUN;
      end
      RUN: begin
        if (flush) begin
          pc_nxt   = flush_pc;
          pend_nxt = 1'b0;
        end else if (branch_flag && stall) begin
          // Newest stalled branch wins over any older buffered one.
          tgt_nxt  = branch_target;
          pend_nxt = 1'b1;
        end else if (branch_flag) begin
          pc_nxt   = branch_target;
          pend_nxt = 1'b0;
        end else if (pend_valid && !stall) begin
          pc_nxt   = pend_tgt;
          pend_nxt = 1'b0;
        end else if (!stall) begin
          pc_nxt   = pc + INC;  // wraps modulo 2^ADDR_WIDTH
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Targets are loaded unaligned; the exception unit watches this flag.
  assign pc_misaligned = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: table-driven vectors through a scoreboard
// queue on a 32-bit instance, plus hand sequences for reset and 8-bit wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, branch_flag = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0, flush_pc = '0;
  logic [31:0] pc;
  logic        ce, pend_valid, pc_misaligned;

  logic        w_stall = 1'b0, w_branch = 1'b0, w_flush = 1'b0;
  logic [7:0]  w_target = '0, w_fpc = '0;
  logic [7:0]  w_pc;
  logic        w_ce, w_pend, w_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .flush_pc(flush_pc),
    .pc(pc), .ce(ce), .pend_valid(pend_valid), .pc_misaligned(pc_misaligned)
  );

  pc_gen #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h00), .PC_INC(4)) dut8 (
    .clk(clk), .rst(rst), .stall(w_stall), .branch_flag(w_branch),
    .branch_target(w_target), .flush(w_flush), .flush_pc(w_fpc),
    .pc(w_pc), .ce(w_ce), .pend_valid(w_pend), .pc_misaligned(w_mis)
  );

  typedef struct {
    logic        rst_before;  // pulse async reset between edges first
    logic        stall, br, fl;
    logic [31:0] bt, fp;
    logic [31:0] epc;
    logic        ece, epend, emis;
  } vec_t;

  typedef struct {
    logic [31:0] epc;
    logic        ece, epend, emis;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rb, logic s, logic b, logic [31:0] bt,
                              logic f, logic [31:0] fp, logic [31:0] epc,
                              logic ece, logic ep, logic em);
    vec_t v;
    v.rst_before = rb; v.stall = s; v.br = b; v.bt = bt; v.fl = f; v.fp = fp;
    v.epc = epc; v.ece = ece; v.epend = ep; v.emis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, push expectation, compare after the edge.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    if (v.rst_before) begin
      #2 rst = 1'b0;
      #1;
      check($sformatf("v%0d async_rst pc", idx), pc, 32'h0);
      check($sformatf("v%0d async_rst ce", idx), {31'b0, ce}, 32'h0);
      check($sformatf("v%0d async_rst pend", idx), {31'b0, pend_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
    end
    stall = v.stall; branch_flag = v.br; branch_target = v.bt;
    flush = v.fl; flush_pc = v.fp;
    e.epc = v.epc; e.ece = v.ece; e.epend = v.epend; e.emis = v.emis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d pc", idx), pc, e.epc);
      check($sformatf("v%0d ce", idx), {31'b0, ce}, {31'b0, e.ece});
      check($sformatf("v%0d pend", idx), {31'b0, pend_valid}, {31'b0, e.epend});
      check($sformatf("v%0d mis", idx), {31'b0, pc_misaligned}, {31'b0, e.emis});
    end
    @(negedge clk);
  endtask

  task automatic wstep(input logic b, input logic [7:0] t, input logic [7:0] epc,
                       input logic emis, input string name);
    w_branch = b; w_target = t;
    @(posedge clk);
    #1;
    check({name, " pc"}, {24'b0, w_pc}, {24'b0, epc});
    check({name, " mis"}, {31'b0, w_mis}, {31'b0, emis});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             rb s  b  bt            f  fp            pc            ce ep em
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0)); // IDLE->RUN
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       1, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h400,      0, 32'h0,        32'h400,      1, 0, 0)); // branch
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h404,      1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        32'h404,      1, 1, 0)); // stalled br
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h404,      1, 1, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h404,      1, 1, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 0, 0)); // release
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        32'h204,      1, 1, 0)); // overwrite
    vt.push_back(mk(0, 1, 1, 32'h300,      0, 32'h0,        32'h204,      1, 1, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h300,      1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h304,      1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        32'h304,      1, 1, 0)); // pending
    vt.push_back(mk(0, 1, 1, 32'h500,      1, 32'h180,      32'h180,      1, 0, 0)); // flush wins
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h180,      1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h184,      1, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h22,       0, 32'h0,        32'h22,       1, 0, 1)); // misaligned
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h26,       1, 0, 1));
    vt.push_back(mk(0, 0, 1, 32'h100,      0, 32'h0,        32'h100,      1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        1, 32'h80000000, 32'h80000000, 1, 0, 0)); // flush
    vt.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,        32'h80000000, 1, 1, 0));
    vt.push_back(mk(1, 1, 1, 32'h999,      1, 32'h777,      32'h0,        1, 0, 0)); // reset, IDLE ignores
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 0));

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset pc", pc, 32'h0);
      check("reset ce", {31'b0, ce}, 32'h0);
      check("reset pend", {31'b0, pend_valid}, 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < vt.size(); i++) step(vt[i], i);

    // 8-bit instance: wraparound and misaligned target.
    wstep(1'b1, 8'hF8, 8'hF8, 1'b0, "w8 branch");
    wstep(1'b0, 8'h00, 8'hFC, 1'b0, "w8 seq");
    wstep(1'b0, 8'h00, 8'h00, 1'b0, "w8 wrap");
    wstep(1'b1, 8'h22, 8'h22, 1'b1, "w8 mis");
    wstep(1'b0, 8'h00, 8'h26, 1'b1, "w8 mis seq");

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard leftover: %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
